// File: rtl/i2s_clock_gen.sv
// Codec clock generator: integer-divided mclk/bclk/lrclk with bit-edge strobes,
// gated by a PLL-lock filter state machine (WAIT_LOCK -> SETTLE -> RUN).
module i2s_clock_gen #(
  parameter int mclk_half_div = 5,
  parameter int bclk_half_div = 2,
  parameter int frame_bits    = 64,
  parameter int lock_filter   = 16
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       mclk,
  output logic       bclk,
  output logic       lrclk,
  output logic       bclk_rise,
  output logic       bclk_fall,
  output logic       frame_start,
  output logic       codec_en,
  output logic       dsp_reset,
  output logic [1:0] state
);

  localparam int MW = (mclk_half_div > 1) ? $clog2(mclk_half_div) : 1;
  localparam int BW = (bclk_half_div > 1) ? $clog2(bclk_half_div) : 1;
  localparam int LW = $clog2(frame_bits);
  localparam int SW = (lock_filter > 1) ? $clog2(lock_filter) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          state_r;
  logic [MW-1:0]   mclk_ctr_r;
  logic            mclk_r;
  logic [SW-1:0]   settle_ctr_r;
  logic [BW-1:0]   bclk_ctr_r;
  logic [LW-1:0]   lr_ctr_r;
  logic            bclk_r;
  logic            lrclk_r;
  logic            bclk_rise_r;
  logic            bclk_fall_r;
  logic            frame_start_r;
  logic            codec_en_r;
  logic            dsp_reset_r;

  logic            mclk_tick_s;
  logic            bclk_step_s;
  logic            bclk_toggle_s;
  logic [LW-1:0]   lr_next_s;

  // Divider terminal counts; the bclk divider advances once per full mclk
  // period (on the mclk rising toggle), so bclk edges sit on mclk rising edges.
  always_comb begin
    mclk_tick_s   = (mclk_ctr_r == MW'(mclk_half_div - 1));
    bclk_step_s   = mclk_tick_s & ~mclk_r;
    bclk_toggle_s = bclk_step_s & (bclk_ctr_r == BW'(bclk_half_div - 1));
    lr_next_s     = lr_ctr_r + {{(LW-1){1'b0}}, 1'b1};
  end

  // Free-running mclk divider, independent of lock state.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mclk_ctr_r <= '0;
      mclk_r     <= 1'b0;
    end else if (mclk_tick_s) begin
      mclk_ctr_r <= '0;
      mclk_r     <= ~mclk_r;
    end else begin
      mclk_ctr_r <= mclk_ctr_r + {{(MW-1){1'b0}}, 1'b1};
    end
  end

  // Lock filter FSM with the RUN-only bclk/lrclk dividers and strobes.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_r       <= WAIT_LOCK;
      settle_ctr_r  <= '0;
      bclk_ctr_r    <= '0;
      lr_ctr_r      <= '0;
      bclk_r        <= 1'b0;
      lrclk_r       <= 1'b0;
      bclk_rise_r   <= 1'b0;
      bclk_fall_r   <= 1'b0;
      frame_start_r <= 1'b0;
      codec_en_r    <= 1'b0;
      dsp_reset_r   <= 1'b1;
    end else begin
      bclk_rise_r   <= 1'b0;
      bclk_fall_r   <= 1'b0;
      frame_start_r <= 1'b0;
      case (state_r)
        WAIT_LOCK: begin
          if (pll_lock) begin
            state_r      <= SETTLE;
            settle_ctr_r <= '0;
          end
        end
        SETTLE: begin
          if (!pll_lock) begin
            state_r      <= WAIT_LOCK;
            settle_ctr_r <= '0;
          end else if (settle_ctr_r == SW'(lock_filter - 1)) begin
            state_r      <= RUN;
            settle_ctr_r <= '0;
            codec_en_r   <= 1'b1;
            dsp_reset_r  <= 1'b0;
          end else begin
            settle_ctr_r <= settle_ctr_r + {{(SW-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
          // Lock loss wins over any coincident bclk edge.
          if (!pll_lock) begin
            state_r     <= WAIT_LOCK;
            bclk_ctr_r  <= '0;
            lr_ctr_r    <= '0;
            bclk_r      <= 1'b0;
            lrclk_r     <= 1'b0;
            codec_en_r  <= 1'b0;
            dsp_reset_r <= 1'b1;
          end else if (bclk_toggle_s) begin
            bclk_ctr_r <= '0;
            bclk_r     <= ~bclk_r;
            if (bclk_r) begin
              bclk_fall_r   <= 1'b1;
              lr_ctr_r      <= lr_next_s;
              lrclk_r       <= lr_next_s[LW-1];
              frame_start_r <= (lr_next_s == '0);
            end else begin
              bclk_rise_r <= 1'b1;
            end
          end else if (bclk_step_s) begin
            bclk_ctr_r <= bclk_ctr_r + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r      <= WAIT_LOCK;
          settle_ctr_r <= '0;
          bclk_ctr_r   <= '0;
          lr_ctr_r     <= '0;
          bclk_r       <= 1'b0;
          lrclk_r      <= 1'b0;
          codec_en_r   <= 1'b0;
          dsp_reset_r  <= 1'b1;
        end
      endcase
    end
  end

  assign mclk        = mclk_r;
  assign bclk        = bclk_r;
  assign lrclk       = lrclk_r;
  assign bclk_rise   = bclk_rise_r;
  assign bclk_fall   = bclk_fall_r;
  assign frame_start = frame_start_r;
  assign codec_en    = codec_en_r;
  assign dsp_reset   = dsp_reset_r;
  assign state       = state_r;

endmodule

// File: tb/tb_i2s_clock_gen.sv
// Self-checking bench for i2s_clock_gen: per-cycle comparison against an
// arithmetic reference model, plus table-driven lock phases and corner sequences.
module tb_i2s_clock_gen;

  localparam int M = 5;
  localparam int B = 2;
  localparam int F = 64;
  localparam int L = 16;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       pll_lock = 1'b0;
  logic       mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, codec_en, dsp_reset;
  logic [1:0] state;

  i2s_clock_gen #(
    .mclk_half_div(M), .bclk_half_div(B), .frame_bits(F), .lock_filter(L)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .pll_lock(pll_lock),
    .mclk(mclk), .bclk(bclk), .lrclk(lrclk),
    .bclk_rise(bclk_rise), .bclk_fall(bclk_fall), .frame_start(frame_start),
    .codec_en(codec_en), .dsp_reset(dsp_reset), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset, consecutive locked samples, and
  // rising mclk ticks seen while in RUN. Everything else is derived by arithmetic.
  int m_n = 0;
  int m_run = 0;
  int m_r = 0;
  bit m_rise = 1'b0, m_fall = 1'b0, m_fs = 1'b0;

  function automatic logic [1:0] m_state(input int run);
    if (run == 0) return 2'd0;
    else if (run <= L) return 2'd1;
    else return 2'd2;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [1:0] s;
    s = m_state(m_run);
    return {1'((m_n / M) % 2), 1'((m_r / B) % 2), 1'(((m_r / (2*B)) % F) >= F/2),
            m_rise, m_fall, m_fs, 1'(s == 2'd2), 1'(s != 2'd2), s};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, codec_en, dsp_reset, state};
  endfunction

  task automatic model_reset();
    m_n = 0; m_run = 0; m_r = 0;
    m_rise = 1'b0; m_fall = 1'b0; m_fs = 1'b0;
  endtask

  task automatic model_edge(input bit lock);
    int  e;
    bit  was_run, rt;
    e       = m_n + 1;
    was_run = (m_state(m_run) == 2'd2);
    rt      = ((e % M) == 0) && (((e / M) % 2) == 1);
    m_n     = e;
    m_rise  = 1'b0; m_fall = 1'b0; m_fs = 1'b0;
    m_run   = lock ? m_run + 1 : 0;
    if (was_run && lock && rt) begin
      m_r++;
      if ((m_r % B) == 0) begin
        if (((m_r / B) % 2) == 1) m_rise = 1'b1;
        else begin
          m_fall = 1'b1;
          m_fs   = ((m_r / (2*B)) % F) == 0;
        end
      end
    end
    if (m_state(m_run) != 2'd2) m_r = 0;
  endtask

  function automatic bit next_is_fall();
    int e;
    e = m_n + 1;
    return (m_state(m_run) == 2'd2) && ((e % M) == 0) && (((e / M) % 2) == 1)
           && (((m_r + 1) % (2*B)) == 0);
  endfunction

  task automatic check_vec(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b (mclk bclk lrclk rise fall fs en drst state)",
               name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic step(input bit lock, input string name);
    pll_lock = lock;
    @(posedge sys_clk);
    model_edge(lock);
    #1;
    check_vec(name, dut_vec(), exp_vec());
  endtask

  typedef struct {
    bit         lock;
    int         cycles;
    logic [1:0] exp_state;
    bit         exp_en;
  } phase_t;

  localparam logic [9:0] RESET_VEC = 10'b0000000100;

  initial begin
    phase_t tbl[8];
    int rises, falls, fss, bhigh, lhigh, waited;
    bit prev_lr;

    tbl[0] = '{1'b0, 40, 2'd0, 1'b0};  // unlocked: idle, mclk only
    tbl[1] = '{1'b1, 16, 2'd1, 1'b0};  // 16 cycles of SETTLE
    tbl[2] = '{1'b1,  1, 2'd2, 1'b1};  // then RUN
    tbl[3] = '{1'b0,  1, 2'd0, 1'b0};  // drop in RUN
    tbl[4] = '{1'b1, 11, 2'd1, 1'b0};  // settle_ctr reaches 10
    tbl[5] = '{1'b0,  1, 2'd0, 1'b0};  // single-cycle glitch
    tbl[6] = '{1'b1, 16, 2'd1, 1'b0};  // fresh filter window
    tbl[7] = '{1'b1,  1, 2'd2, 1'b1};

    // Reset held 3 cycles
    repeat (3) @(posedge sys_clk);
    #1;
    check_vec("reset_values", dut_vec(), RESET_VEC);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].lock, "phase_cycle");
      check_int("phase_state", int'(state), int'(tbl[i].exp_state));
      check_int("phase_codec_en", int'(codec_en), int'(tbl[i].exp_en));
    end

    // Steady RUN: one full frame of activity
    rises = 0; falls = 0; fss = 0; bhigh = 0; lhigh = 0;
    for (int c = 0; c < 2560; c++) begin
      prev_lr = lrclk;
      step(1'b1, "steady_cycle");
      rises += int'(bclk_rise);
      falls += int'(bclk_fall);
      bhigh += int'(bclk);
      lhigh += int'(lrclk);
      if (frame_start) begin
        fss++;
        check_int("fs_alignment", int'({prev_lr, lrclk, bclk_fall}), 3'b101);
      end
    end
    check_int("rises_per_frame", rises, 64);
    check_int("falls_per_frame", falls, 64);
    check_int("frame_starts", fss, 1);
    check_int("bclk_high_cycles", bhigh, 1280);
    check_int("lrclk_high_cycles", lhigh, 1280);

    // Lock loss on a cycle where bclk would fall
    waited = 0;
    while (!next_is_fall() && waited < 200) begin
      step(1'b1, "pre_drop_cycle");
      waited++;
    end
    check_int("drop_wait_bound", int'(waited < 200), 1);
    step(1'b0, "drop_on_fall");
    check_int("drop_no_fall", int'(bclk_fall), 0);
    check_int("drop_state", int'(state), 0);
    for (int c = 0; c < 20; c++) step(1'b0, "post_drop_mclk");

    // Relock, wait for lrclk=1, then async reset mid-cycle
    for (int c = 0; c < 17; c++) step(1'b1, "relock_cycle");
    waited = 0;
    while (lrclk !== 1'b1 && waited < 3000) begin
      step(1'b1, "wait_lrclk");
      waited++;
    end
    check_int("lrclk_wait_bound", int'(lrclk), 1);
    repeat (7) step(1'b1, "pre_reset_cycle");
    #2 reset = 1'b1;
    #1;
    check_vec("async_reset_values", dut_vec(), RESET_VEC);
    model_reset();
    @(posedge sys_clk);
    #1;
    check_vec("reset_held", dut_vec(), RESET_VEC);
    reset = 1'b0;

    // First frame_start after re-entry must follow 64 falls
    for (int c = 0; c < 17; c++) step(1'b1, "relock2_cycle");
    falls = 0; waited = 0;
    while (waited < 4000) begin
      step(1'b1, "first_frame_cycle");
      falls += int'(bclk_fall);
      waited++;
      if (frame_start) break;
    end
    check_int("first_frame_start_falls", falls, 64);

    // Randomized lock behaviour
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) step(1'b0, "random_cycle");
      else step(1'b1, "random_cycle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
